// File: rtl/eth_pkg.sv
// Shared Ethernet header constants, inserter FSM encoding and tkeep helpers.
package eth_pkg;

    localparam int ETH_HDR_BYTES = 14;
    localparam int ETH_MAC_W     = 48;
    localparam int ETH_TYPE_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR1    = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_FLUSH   = 2'd3
    } eth_state_t;

    function automatic logic [3:0] keep_popcount(input logic [7:0] keep);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/eth_hdr_axis_inserter_out_reg.sv
// AXI-Stream output register with a holding slot, so the upstream ready can be
// registered without losing a beat when the sink stalls.
module axis_out_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_tdata,
    input  logic [KEEP_WIDTH-1:0] i_tkeep,
    input  logic                  i_tvalid,
    input  logic                  i_tlast,
    input  logic                  i_tuser,
    output logic                  o_tready,
    output logic                  o_tready_early,
    output logic [DATA_WIDTH-1:0] o_m_tdata,
    output logic [KEEP_WIDTH-1:0] o_m_tkeep,
    output logic                  o_m_tvalid,
    output logic                  o_m_tlast,
    output logic                  o_m_tuser,
    input  logic                  i_m_tready
);

    // Handshake: a beat moves on any edge where valid && ready. i_tvalid may
    // only be raised while o_tready (registered) is high; o_tready_early is
    // the value o_tready takes after the next edge.
    logic [DATA_WIDTH-1:0] r_m_tdata, r_t_tdata;
    logic [KEEP_WIDTH-1:0] r_m_tkeep, r_t_tkeep;
    logic                  r_m_tvalid, r_m_tlast, r_m_tuser;
    logic                  r_t_tvalid, r_t_tlast, r_t_tuser;
    logic                  r_ready;

    assign o_tready_early = i_m_tready || (!r_t_tvalid && (!r_m_tvalid || !i_tvalid));
    assign o_tready   = r_ready;
    assign o_m_tdata  = r_m_tdata;
    assign o_m_tkeep  = r_m_tkeep;
    assign o_m_tvalid = r_m_tvalid;
    assign o_m_tlast  = r_m_tlast;
    assign o_m_tuser  = r_m_tuser;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready    <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= 1'b0;
            r_t_tdata  <= '0;
            r_t_tkeep  <= '0;
            r_t_tvalid <= 1'b0;
            r_t_tlast  <= 1'b0;
            r_t_tuser  <= 1'b0;
        end else begin
            r_ready <= o_tready_early;
            if (r_ready) begin
                if (i_m_tready || !r_m_tvalid) begin
                    r_m_tvalid <= i_tvalid;
                    r_m_tdata  <= i_tdata;
                    r_m_tkeep  <= i_tkeep;
                    r_m_tlast  <= i_tlast;
                    r_m_tuser  <= i_tuser;
                end else begin
                    r_t_tvalid <= i_tvalid;
                    r_t_tdata  <= i_tdata;
                    r_t_tkeep  <= i_tkeep;
                    r_t_tlast  <= i_tlast;
                    r_t_tuser  <= i_tuser;
                end
            end else if (i_m_tready) begin
                r_m_tvalid <= r_t_tvalid;
                r_m_tdata  <= r_t_tdata;
                r_m_tkeep  <= r_t_tkeep;
                r_m_tlast  <= r_t_tlast;
                r_m_tuser  <= r_t_tuser;
                r_t_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/eth_hdr_axis_inserter.sv
// Prepends a 14-byte Ethernet header to a 64-bit AXI-Stream payload, shifting
// the payload by 2 bytes and flushing the trailing residue when needed.
module eth_hdr_axis_inserter
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_eth_hdr_valid,
    output logic                  s_eth_hdr_ready,
    input  logic [ETH_MAC_W-1:0]  s_eth_dest_mac,
    input  logic [ETH_MAC_W-1:0]  s_eth_src_mac,
    input  logic [ETH_TYPE_W-1:0] s_eth_type,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic [1:0]            o_state
);

    if (DATA_WIDTH != 64) begin : g_bad_width
        $error("eth_hdr_axis_inserter supports only DATA_WIDTH=64");
    end

    eth_state_t      r_state, w_state_next;
    logic            r_hdr_ready, r_tready;
    logic [31:0]     r_src_lo;
    logic [15:0]     r_type;
    logic [47:0]     r_residue;
    logic [7:0]      r_last_keep;
    logic            r_tuser;
    logic [1:0]      r_frames;
    logic            w_hdr_fire, w_pay_fire, w_last_short, w_last_out;
    logic [DATA_WIDTH-1:0] w_int_tdata;
    logic [KEEP_WIDTH-1:0] w_int_tkeep;
    logic            w_int_tvalid, w_int_tlast, w_int_tuser;
    logic            w_out_ready, w_out_ready_early;

    assign w_hdr_fire      = s_eth_hdr_valid && r_hdr_ready;
    assign w_pay_fire      = s_axis_tvalid && r_tready;
    assign w_last_short    = keep_popcount(s_axis_tkeep) <= 4'd2;
    assign w_last_out      = m_axis_tvalid && m_axis_tready && m_axis_tlast;
    assign s_eth_hdr_ready = r_hdr_ready;
    assign s_axis_tready   = r_tready;
    assign busy            = (r_frames != 2'd0);
    assign o_state         = r_state;

    always_comb begin
        w_state_next = r_state;
        w_int_tvalid = 1'b0;
        w_int_tdata  = '0;
        w_int_tkeep  = '0;
        w_int_tlast  = 1'b0;
        w_int_tuser  = 1'b0;
        case (r_state)
            ST_IDLE: if (w_hdr_fire) begin
                w_int_tvalid = 1'b1;
                w_int_tdata  = {s_eth_src_mac[39:32], s_eth_src_mac[47:40],
                                s_eth_dest_mac[7:0], s_eth_dest_mac[15:8],
                                s_eth_dest_mac[23:16], s_eth_dest_mac[31:24],
                                s_eth_dest_mac[39:32], s_eth_dest_mac[47:40]};
                w_int_tkeep  = 8'hFF;
                w_state_next = ST_HDR1;
            end
            ST_HDR1, ST_PAYLOAD: if (w_pay_fire) begin
                w_int_tvalid        = 1'b1;
                w_int_tdata[63:48]  = s_axis_tdata[15:0];
                w_int_tdata[47:0]   = (r_state == ST_HDR1) ?
                    {r_type[7:0], r_type[15:8], r_src_lo[7:0], r_src_lo[15:8],
                     r_src_lo[23:16], r_src_lo[31:24]} : r_residue;
                w_int_tkeep  = 8'hFF;
                w_state_next = ST_PAYLOAD;
                // A last beat with at most 2 bytes fits entirely in this output beat.
                if (s_axis_tlast) begin
                    if (w_last_short) begin
                        w_int_tkeep  = {s_axis_tkeep[1:0], 6'h3F};
                        w_int_tlast  = 1'b1;
                        w_int_tuser  = s_axis_tuser;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: if (w_out_ready) begin
                w_int_tvalid = 1'b1;
                w_int_tdata  = {16'h0000, r_residue};
                w_int_tkeep  = r_last_keep;
                w_int_tlast  = 1'b1;
                w_int_tuser  = r_tuser;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hdr_ready <= 1'b0;
            r_tready    <= 1'b0;
            r_src_lo    <= '0;
            r_type      <= '0;
            r_residue   <= '0;
            r_last_keep <= '0;
            r_tuser     <= 1'b0;
            r_frames    <= 2'd0;
        end else begin
            r_state     <= w_state_next;
            r_hdr_ready <= w_out_ready_early && (w_state_next == ST_IDLE);
            r_tready    <= w_out_ready_early &&
                           (w_state_next == ST_HDR1 || w_state_next == ST_PAYLOAD);
            if (w_hdr_fire) begin
                r_src_lo <= s_eth_src_mac[31:0];
                r_type   <= s_eth_type;
            end
            if (w_pay_fire) begin
                r_residue   <= s_axis_tdata[63:16];
                r_last_keep <= {2'b00, s_axis_tkeep[7:2]};
                r_tuser     <= s_axis_tuser;
            end
            // Frames in flight: a new header may be taken while the previous tail drains.
            case ({w_hdr_fire, w_last_out})
                2'b10:   r_frames <= r_frames + 2'd1;
                2'b01:   r_frames <= r_frames - 2'd1;
                default: r_frames <= r_frames;
            endcase
        end
    end

    axis_out_reg #(
        .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH)
    ) u_out_reg (
        .clk            (clk),
        .rst            (rst),
        .i_tdata        (w_int_tdata),
        .i_tkeep        (w_int_tkeep),
        .i_tvalid       (w_int_tvalid),
        .i_tlast        (w_int_tlast),
        .i_tuser        (w_int_tuser),
        .o_tready       (w_out_ready),
        .o_tready_early (w_out_ready_early),
        .o_m_tdata      (m_axis_tdata),
        .o_m_tkeep      (m_axis_tkeep),
        .o_m_tvalid     (m_axis_tvalid),
        .o_m_tlast      (m_axis_tlast),
        .o_m_tuser      (m_axis_tuser),
        .i_m_tready     (m_axis_tready)
    );

endmodule
